// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared constants for the logic unit pipeline: operation
//                select encodings and default datapath/buffer sizes.
//  Revision    : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_depth = 2;

    // Operation select encodings. OR/AND keep the legacy select on bit 0.
    localparam logic [2:0] c_op_or   = 3'b000;
    localparam logic [2:0] c_op_and  = 3'b001;
    localparam logic [2:0] c_op_xor  = 3'b010;
    localparam logic [2:0] c_op_nor  = 3'b011;
    localparam logic [2:0] c_op_andn = 3'b100;
    localparam logic [2:0] c_op_orn  = 3'b101;
    localparam logic [2:0] c_op_xnor = 3'b110;
    localparam logic [2:0] c_op_passb = 3'b111;

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/logic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : logic_fifo
//  Description : Synchronous FIFO used as the result buffer. Pushes are
//                dropped when full, pops are ignored when empty. Output data
//                reads as zero while empty.
//  Ports       : clk, reset (sync, active-high)
//                i_push / i_data  - write request and payload
//                i_pop            - consumer takes the head entry
//                o_full, o_valid  - registered occupancy status
//                o_data           - head entry (zero when empty)
//  Revision    : 1.0  initial release
// ============================================================================
module logic_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_valid   = (r_count != '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & o_valid;
    assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : logic_fifo
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Bitwise logic unit with an accumulator and a buffered,
//                ready/valid result interface. Results carry zero and parity
//                flags computed before buffering.
//  Ports       : clk, reset (sync, active-high)
//                in_valid/in_ready, in_a, in_b, in_op, in_acc, acc_clr
//                out_valid/out_ready, out_y, out_zero, out_par
//                op_count - saturating count of accepted requests
//  Revision    : 1.0  initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_par,
    output logic [15:0]      op_count
);

    logic [WIDTH-1:0] r_acc;
    logic [15:0]      r_op_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH+1:0] w_push_data;
    logic [WIDTH+1:0] w_head_data;
    logic             w_fifo_full;
    logic             w_fifo_valid;
    logic             w_show;

    assign in_ready = ~w_fifo_full & ~reset;
    assign w_accept = in_valid & in_ready;

    // A clear on an accumulate cycle turns the accumulator operand into zero.
    assign w_a_eff = in_acc ? (acc_clr ? '0 : r_acc) : in_a;

    always_comb begin
        w_y = in_b;
        case (in_op)
            c_op_or:    w_y = w_a_eff | in_b;
            c_op_and:   w_y = w_a_eff & in_b;
            c_op_xor:   w_y = w_a_eff ^ in_b;
            c_op_nor:   w_y = ~(w_a_eff | in_b);
            c_op_andn:  w_y = w_a_eff & ~in_b;
            c_op_orn:   w_y = w_a_eff | ~in_b;
            c_op_xnor:  w_y = ~(w_a_eff ^ in_b);
            c_op_passb: w_y = in_b;
            default:    w_y = in_b;
        endcase
    end

    // Payload layout: {parity, zero, result}.
    assign w_push_data = {^w_y, (w_y == '0), w_y};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_y;
            end else if (acc_clr) begin
                r_acc <= '0;
            end
            if (w_accept && (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    logic_fifo #(
        .WIDTH (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_push_data),
        .i_pop   (out_ready & ~reset),
        .o_full  (w_fifo_full),
        .o_valid (w_fifo_valid),
        .o_data  (w_head_data)
    );

    // Outputs are forced quiet while reset is held, even before its edge.
    assign w_show    = w_fifo_valid & ~reset;
    assign out_valid = w_show;
    assign out_y     = w_show ? w_head_data[WIDTH-1:0] : '0;
    assign out_zero  = w_show & w_head_data[WIDTH];
    assign out_par   = w_show & w_head_data[WIDTH+1];
    assign op_count  = reset ? 16'd0 : r_op_count;

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_pipe
//  Description : Directed self-checking bench for logic_unit_pipe
//                (WIDTH=8, DEPTH=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_par;
    logic [15:0]      op_count;

    int total = 0;
    int bad   = 0;

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_par   (out_par),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc, input logic clr);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        acc_clr  = clr;
    endtask

    initial begin
        logic [7:0] exp_y [8];
        int n;
        exp_y = '{8'hFC, 8'h30, 8'hCC, 8'h03, 8'hC0, 8'hF3, 8'h33, 8'h3C};

        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        step();

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", {24'd0, out_y}, 32'd0);
        chk("rst_flags", {30'd0, out_par, out_zero}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);

        reset = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // All eight operations, streaming with out_ready=1
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 8'hF0, 8'h3C, 3'(op), 1'b0, 1'b0);
            step();
            chk($sformatf("op%0d_valid", op), {31'd0, out_valid}, 32'd1);
            chk($sformatf("op%0d_y", op), {24'd0, out_y}, {24'd0, exp_y[op]});
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_y", {24'd0, out_y}, 32'd0);
        chk("cnt_after_ops", {16'd0, op_count}, 32'd8);

        // Flags
        drive(1'b1, 8'hAA, 8'h55, 3'b001, 1'b0, 1'b0);
        step();
        chk("and_y", {24'd0, out_y}, 32'h00);
        chk("and_zero", {31'd0, out_zero}, 32'd1);
        chk("and_par", {31'd0, out_par}, 32'd0);
        drive(1'b1, 8'h01, 8'h00, 3'b010, 1'b0, 1'b0);
        step();
        chk("xor_y", {24'd0, out_y}, 32'h01);
        chk("xor_zero", {31'd0, out_zero}, 32'd0);
        chk("xor_par", {31'd0, out_par}, 32'd1);

        // Accumulator
        drive(1'b1, 8'h0F, 8'h00, 3'b000, 1'b0, 1'b0);
        step();
        chk("acc1_y", {24'd0, out_y}, 32'h0F);
        drive(1'b1, 8'h00, 8'hF0, 3'b010, 1'b1, 1'b0);
        step();
        chk("acc2_y", {24'd0, out_y}, 32'hFF);
        drive(1'b1, 8'hAA, 8'h55, 3'b000, 1'b1, 1'b1);
        step();
        chk("acc3_y", {24'd0, out_y}, 32'h55);
        // Clear without accept, then accumulate against the cleared value
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'hFF, 8'h00, 3'b000, 1'b1, 1'b0);
        step();
        chk("acc_clr_idle_y", {24'd0, out_y}, 32'h00);
        chk("cnt_after_acc", {16'd0, op_count}, 32'd14);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // Backpressure: three requests offered against a two-entry buffer
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 3'b000, 1'b0, 1'b0);
        step();
        chk("bp1_y", {24'd0, out_y}, 32'h33);
        chk("bp1_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'h0F, 8'hF0, 3'b010, 1'b0, 1'b0);
        step();
        chk("bp2_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_y", {24'd0, out_y}, 32'h33);
        drive(1'b1, 8'h80, 8'h01, 3'b000, 1'b0, 1'b0);
        step();
        chk("bp3_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3_y", {24'd0, out_y}, 32'h33);
        chk("bp3_cnt", {16'd0, op_count}, 32'd16);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_y", {24'd0, out_y}, 32'hFF);
        chk("bp_pop1_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_pop2_y", {24'd0, out_y}, 32'h81);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_cnt", {16'd0, op_count}, 32'd17);

        // Reset with a full buffer
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 3'b000, 1'b0, 1'b0);
        step();
        step();
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_cnt", {16'd0, op_count}, 32'd19);
        reset     = 1'b1;
        out_ready = 1'b1;
        acc_clr   = 1'b1;
        step();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_cnt", {16'd0, op_count}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        chk("mrst_rel_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 8'hFF, 8'h5A, 3'b000, 1'b1, 1'b0);
        step();
        chk("mrst_acc_zero", {24'd0, out_y}, 32'h5A);
        chk("mrst_cnt1", {16'd0, op_count}, 32'd1);

        // Saturation of op_count
        drive(1'b1, 8'h01, 8'h02, 3'b000, 1'b0, 1'b0);
        n = 0;
        while (op_count != 16'hFFFE && n < 70000) begin
            step();
            n++;
        end
        chk("sat_reach", {16'd0, op_count}, 32'hFFFE);
        step();
        chk("sat_1", {16'd0, op_count}, 32'hFFFF);
        step();
        chk("sat_2", {16'd0, op_count}, 32'hFFFF);
        step();
        chk("sat_3", {16'd0, op_count}, 32'hFFFF);
        chk("sat_ready", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_logic_unit_pipe
`default_nettype wire
